jtcps1_gfx_arbiter: RTL

//  Shares the single GFX ROM read port among NREQ fetch engines (scroll layers, sprites).

---
 rtl/jtcps1_gfx_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/jtcps1_gfx_arbiter.sv
// rtl/jtcps1_gfx_arbiter.sv - round-robin sharer of the GFX ROM read port with per-requester result register
//
// Ports:
//   rst       in   1        asynchronous active-high reset
//   clk       in   1        clock
//   req_cs    in   NREQ     per-requester read request, held until its req_ok
//   req_addr  in   NREQ*AW  requester i address in [i*AW +: AW]
//   req_ok    out  NREQ     requester i data valid for its current address
//   req_data  out  NREQ*32  requester i data in [i*32 +: 32]
//   rom_cs    out  1        ROM read request
//   rom_addr  out  AW       ROM address
//   rom_ok    in   1        ROM data valid (may be stale one cycle after rom_addr moves)
//   rom_data  in   32       ROM read data
module jtcps1_gfx_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 23
) (
    input  logic                 rst,
    input  logic                 clk,
    input  logic [NREQ-1:0]      req_cs,
    input  logic [NREQ*AW-1:0]   req_addr,
    output logic [NREQ-1:0]      req_ok,
    output logic [NREQ*32-1:0]   req_data,
    output logic                 rom_cs,
    output logic [AW-1:0]        rom_addr,
    input  logic                 rom_ok,
    input  logic [31:0]          rom_data
);

    localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic               r_blank;
    logic [RW-1:0]      r_rr;
    logic [RW-1:0]      r_gnt;
    logic [NREQ-1:0]    r_valid;
    logic [AW-1:0]      r_addr_q [NREQ];
    logic [31:0]        r_data_q [NREQ];

    logic [NREQ-1:0]    w_pending;
    logic               w_found;
    logic [RW-1:0]      w_sel;
    logic [AW-1:0]      w_sel_addr;
    logic               w_grant;
    logic               w_capture;

    // Local hit check: a requester whose entry already holds its address is
    // answered without touching the ROM.
    always_comb begin
        req_ok   = '0;
        req_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ok[i]         = req_cs[i] & r_valid[i] & (req_addr[i*AW +: AW] == r_addr_q[i]);
            req_data[i*32 +: 32] = r_data_q[i];
        end
    end

    assign w_pending = req_cs & ~req_ok;

    // Round robin: the lowest pending index above the last grant wins;
    // otherwise wrap around to the lowest pending index overall.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = NREQ-1; i >= 0; i--) begin
            if (w_pending[i]) begin
                w_found = 1'b1;
                w_sel   = RW'(i);
            end
        end
        for (int i = NREQ-1; i >= 0; i--) begin
            if (w_pending[i] && (i > int'(r_rr))) begin
                w_sel = RW'(i);
            end
        end
    end

    always_comb begin
        w_sel_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_sel == RW'(i)) begin
                w_sel_addr = req_addr[i*AW +: AW];
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: if (w_found) w_state_nx = ST_WAIT;
            ST_WAIT: if (!r_blank && rom_ok) w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // Output/control decode. The first WAIT cycle (blank) discards rom_ok,
    // which may still refer to the previous address.
    always_comb begin
        w_grant   = (r_state == ST_IDLE) && w_found;
        w_capture = (r_state == ST_WAIT) && !r_blank && rom_ok;
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_blank  <= 1'b0;
            r_rr     <= RW'(NREQ-1);
            r_gnt    <= '0;
            r_valid  <= '0;
            rom_cs   <= 1'b0;
            rom_addr <= '0;
            for (int i = 0; i < NREQ; i++) begin
                r_addr_q[i] <= '0;
                r_data_q[i] <= '0;
            end
        end else begin
            r_state <= w_state_nx;
            if (w_grant) begin
                r_rr     <= w_sel;
                r_gnt    <= w_sel;
                rom_addr <= w_sel_addr;
                rom_cs   <= 1'b1;
                r_blank  <= 1'b1;
            end
            if (r_state == ST_WAIT && r_blank) begin
                r_blank <= 1'b0;
            end
            if (w_capture) begin
                rom_cs <= 1'b0;
                for (int i = 0; i < NREQ; i++) begin
                    if (r_gnt == RW'(i)) begin
                        r_data_q[i] <= rom_data;
                        r_addr_q[i] <= rom_addr;
                        r_valid[i]  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
